// File: rtl/sys_defs.sv
// Shared rename-path definitions: free-list sizing, tag/pointer types and packet structs.
package sys_defs;

  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_FL   = NUM_PR - NUM_ARCH;  // must be a power of 2
  localparam int PR_IDX_W = $clog2(NUM_PR);
  localparam int FL_IDX_W = $clog2(NUM_FL);
  localparam int FL_PTR_W = FL_IDX_W + 1;       // extra MSB is the wrap bit

  typedef logic [PR_IDX_W-1:0] pr_tag_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef struct packed {
    logic    dispatch;
    logic    retire;
    pr_tag_t T_old;
    logic    rollback;
    fl_ptr_t rollback_head;
  } FL_PACKET_IN;

  typedef struct packed {
    pr_tag_t T;
    fl_ptr_t head;
    logic    empty;
    fl_ptr_t count;
  } FL_PACKET_OUT;

endpackage

// File: rtl/free_list_if.sv
// Rename-stage <-> free-list port bundle. Inputs are sampled on the rising clock edge;
// T_out/head_out/empty/count_out are combinational views of the current head state.
interface free_list_if;
  import sys_defs::*;

  logic    en;
  logic    dispatch_en;
  logic    retire_en;
  pr_tag_t T_old_in;
  logic    rollback_en;
  fl_ptr_t rollback_head_in;
  pr_tag_t T_out;
  fl_ptr_t head_out;
  logic    empty;
  fl_ptr_t count_out;

  modport master (
    output en, dispatch_en, retire_en, T_old_in, rollback_en, rollback_head_in,
    input  T_out, head_out, empty, count_out
  );

  modport slave (
    input  en, dispatch_en, retire_en, T_old_in, rollback_en, rollback_head_in,
    output T_out, head_out, empty, count_out
  );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with checkpoint rollback of the head pointer.
// Optional FREELIST_BYPASS_EN forwards a retiring tag straight to dispatch when the list is empty.
module free_list
  import sys_defs::*;
(
  input  logic      clock,
  input  logic      reset,
  free_list_if.slave fl
);

  FL_PACKET_IN  in_pkt;
  FL_PACKET_OUT out_pkt;

  pr_tag_t entry_q [NUM_FL];
  pr_tag_t entry_d [NUM_FL];
  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t count;
  logic    empty_raw;
  logic    pop;
  logic    push;
  logic    bypass;

  assign in_pkt = '{dispatch:      fl.dispatch_en,
                    retire:        fl.retire_en,
                    T_old:         fl.T_old_in,
                    rollback:      fl.rollback_en,
                    rollback_head: fl.rollback_head_in};

  always_comb begin
    count     = tail_q - head_q;
    empty_raw = (count == '0);
`ifdef FREELIST_BYPASS_EN
    bypass    = empty_raw && fl.en && in_pkt.retire && in_pkt.dispatch && !in_pkt.rollback;
`else
    bypass    = 1'b0;
`endif
    pop  = fl.en && in_pkt.dispatch && !empty_raw && !in_pkt.rollback;
    // A bypassed tag goes straight to dispatch, so it never enters storage.
    push = fl.en && in_pkt.retire && !bypass;

    head_d = head_q;
    if (fl.en && in_pkt.rollback) begin
      head_d = in_pkt.rollback_head;
    end else if (pop) begin
      head_d = head_q + fl_ptr_t'(1);
    end

    tail_d  = push ? tail_q + fl_ptr_t'(1) : tail_q;
    entry_d = entry_q;
    if (push) begin
      entry_d[tail_q[FL_IDX_W-1:0]] = in_pkt.T_old;
    end

    out_pkt.T     = bypass ? in_pkt.T_old : entry_q[head_q[FL_IDX_W-1:0]];
    out_pkt.head  = head_q;
    out_pkt.empty = empty_raw && !bypass;
    out_pkt.count = count;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(NUM_FL);
      for (int i = 0; i < NUM_FL; i++) begin
        entry_q[i] <= pr_tag_t'(NUM_ARCH + i);
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      entry_q <= entry_d;
    end
  end

  assign fl.T_out     = out_pkt.T;
  assign fl.head_out  = out_pkt.head;
  assign fl.empty     = out_pkt.empty;
  assign fl.count_out = out_pkt.count;

endmodule
